// File: rtl/switch_select_pkg.sv
// Shared types and helpers for the switch-driven demux select controller.
package switch_select_pkg;

    localparam int unsigned SEL_W  = 2;
    localparam int unsigned NUM_CH = 4;

    typedef enum logic {
        DB_LOW,
        DB_HIGH
    } db_state_e;

    // Step the channel index up or down; SEL_W bits wrap modulo NUM_CH.
    function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] idx, input logic up);
        return up ? SEL_W'(idx + 1'b1) : SEL_W'(idx - 1'b1);
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a LOW/HIGH debounce FSM. o_rise pulses for one
// cycle when a press is accepted; a release is accepted silently.
module debounce_filter
    import switch_select_pkg::*;
#(
    parameter int unsigned LIMIT = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int unsigned CntW = $clog2(LIMIT + 1);

    logic            sync1_q;
    logic            sync2_q;
    db_state_e       state_q;
    logic [CntW-1:0] cnt_q;
    logic            rise_q;
    logic            target;

    // Level that would move the FSM to the other state.
    assign target = (state_q == DB_LOW);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= DB_LOW;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= i_raw;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            if (sync2_q == target) begin
                if (cnt_q == CntW'(LIMIT - 1)) begin
                    cnt_q   <= '0;
                    state_q <= target ? DB_HIGH : DB_LOW;
                    rise_q  <= target;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign o_level = (state_q == DB_HIGH);
    assign o_rise  = rise_q;

endmodule

// File: rtl/switch_select_ctrl.sv
// Debounced up/down channel selector driving the 1-to-4 LED demux select lines.
// Optional idle auto-advance is enabled by defining SWITCH_SELECT_AUTO_SCAN_EN.
module switch_select_ctrl
    import switch_select_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = 250000,
    parameter int unsigned AUTO_LIMIT     = 25000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_switch_1,
    input  logic i_switch_2,
    output logic o_sel0,
    output logic o_sel1,
    output logic o_press
);

    logic             rise1;
    logic             rise2;
    logic             level1;
    logic             level2;
    logic             unused_level;
    logic [SEL_W-1:0] idx_q;
    logic [SEL_W-1:0] idx_d;
    logic             press_q;
    logic             press_d;

    debounce_filter #(
        .LIMIT (DEBOUNCE_LIMIT)
    ) u_db_up (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_raw   (i_switch_1),
        .o_level (level1),
        .o_rise  (rise1)
    );

    debounce_filter #(
        .LIMIT (DEBOUNCE_LIMIT)
    ) u_db_down (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_raw   (i_switch_2),
        .o_level (level2),
        .o_rise  (rise2)
    );

    // Only the press edges steer the index; settled levels are not needed here.
    assign unused_level = level1 ^ level2;

`ifdef SWITCH_SELECT_AUTO_SCAN_EN
    localparam int unsigned IdleW = $clog2(AUTO_LIMIT + 1);

    logic [IdleW-1:0] idle_q;
    logic [IdleW-1:0] idle_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic [31:0] unused_auto_limit;
    assign unused_auto_limit = AUTO_LIMIT;
`endif

    always_comb begin
        idx_d   = idx_q;
        press_d = 1'b0;
        // Simultaneous up and down presses cancel.
        if (rise1 ^ rise2) begin
            idx_d   = sel_step(idx_q, rise1);
            press_d = 1'b1;
        end
`ifdef SWITCH_SELECT_AUTO_SCAN_EN
        idle_d = idle_q + 1'b1;
        if (rise1 | rise2) begin
            idle_d = '0;
        end else if (idle_q == IdleW'(AUTO_LIMIT - 1)) begin
            idle_d = '0;
            idx_d  = sel_step(idx_q, 1'b1);
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx_q   <= '0;
            press_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            press_q <= press_d;
        end
    end

    assign o_sel0  = idx_q[0];
    assign o_sel1  = idx_q[1];
    assign o_press = press_q;

endmodule

// File: tb/tb_switch_select_ctrl.sv
// Self-checking bench for switch_select_ctrl: directed table, corner sequences and random
// switch activity compared cycle by cycle against a window-based reference model.
module tb_switch_select_ctrl;

    localparam int unsigned LIMIT = 8;
    localparam int unsigned AUTO  = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sw1   = 1'b0;
    logic sw2   = 1'b0;
    logic sel0;
    logic sel1;
    logic press;

    int checks    = 0;
    int errors    = 0;
    int press_cnt = 0;

    // Reference model state: raw samples per switch, accepted levels, pending rises.
    bit hist1[$];
    bit hist2[$];
    bit lvl1, lvl2, rise1_p, rise2_p, press_m;
    int idx_m;
    int idle_m;

    typedef struct {
        logic s1;
        logic s2;
        int   hold;
        int   exp_idx;
        int   exp_press;
    } vec_t;

    vec_t tbl[10];

    switch_select_ctrl #(
        .DEBOUNCE_LIMIT (LIMIT),
        .AUTO_LIMIT     (AUTO)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_switch_1 (sw1),
        .i_switch_2 (sw2),
        .o_sel0     (sel0),
        .o_sel1     (sel1),
        .o_press    (press)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // True when the raw samples that have reached the filter over the last LIMIT
    // cycles (two-cycle sync delay) all equal v.
    function automatic bit settled(input bit h[$], input bit v);
        int n;
        n = h.size();
        for (int k = n - 1 - int'(LIMIT); k <= n - 2; k++) begin
            if (h[k] != v) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist1 = {};
        hist2 = {};
        for (int k = 0; k <= int'(LIMIT); k++) begin
            hist1.push_back(1'b0);
            hist2.push_back(1'b0);
        end
        lvl1 = 0; lvl2 = 0; rise1_p = 0; rise2_p = 0; press_m = 0;
        idx_m = 0; idle_m = 0;
    endtask

    task automatic model_edge();
        bit r1, r2;
        press_m = 0;
        if (rise1_p != rise2_p) begin
            idx_m   = rise1_p ? (idx_m + 1) % 4 : (idx_m + 3) % 4;
            press_m = 1;
        end
`ifdef SWITCH_SELECT_AUTO_SCAN_EN
        if (rise1_p || rise2_p) idle_m = 0;
        else if (idle_m == int'(AUTO) - 1) begin
            idx_m  = (idx_m + 1) % 4;
            idle_m = 0;
        end else idle_m++;
`endif
        r1 = 0;
        r2 = 0;
        if (settled(hist1, !lvl1)) begin lvl1 = !lvl1; r1 = lvl1; end
        if (settled(hist2, !lvl2)) begin lvl2 = !lvl2; r2 = lvl2; end
        rise1_p = r1;
        rise2_p = r2;
        hist1.push_back(sw1);
        hist2.push_back(sw2);
        void'(hist1.pop_front());
        void'(hist2.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check("sel_track", int'({sel1, sel0}), idx_m);
        check("press_track", int'(press), int'(press_m));
        if (press) press_cnt++;
    endtask

    task automatic do_reset();
        sw1   = 0;
        sw2   = 0;
        rst_n = 0;
        model_reset();
        #1;
        check("reset_sel", int'({sel1, sel0}), 0);
        check("reset_press", int'(press), 0);
        repeat (3) tick();
        rst_n     = 1;
        press_cnt = 0;
    endtask

    task automatic wait_change(input int budget, output int n);
        logic [1:0] start;
        start = {sel1, sel0};
        n = 0;
        do begin
            tick();
            n++;
        end while ({sel1, sel0} == start && n < budget);
    endtask

    initial begin
        int n;
        int rem1, rem2;

        tbl[0] = '{1'b1, 1'b0, 20, 1, 1};
        tbl[1] = '{1'b1, 1'b0, 20, 2, 1};
        tbl[2] = '{1'b1, 1'b0, 20, 3, 1};
        tbl[3] = '{1'b1, 1'b0, 20, 0, 1};
        tbl[4] = '{1'b0, 1'b1, 20, 3, 1};
        tbl[5] = '{1'b1, 1'b1, 20, 3, 0};
        tbl[6] = '{1'b1, 1'b0, 5,  3, 0};
        tbl[7] = '{1'b1, 1'b0, 7,  3, 0};
        tbl[8] = '{1'b1, 1'b0, 8,  0, 1};
        tbl[9] = '{1'b0, 1'b1, 8,  3, 1};

        do_reset();
        repeat (100) tick();

`ifndef SWITCH_SELECT_AUTO_SCAN_EN
        check("idle_no_press", press_cnt, 0);
        check("idle_sel", int'({sel1, sel0}), 0);

        // Press latency from a clean edge, and no repeat while held.
        do_reset();
        sw1 = 1;
        wait_change(40, n);
        check("press_latency", n, 11);
        repeat (20) tick();
        sw1 = 0;
        repeat (14) tick();
        check("held_single_step", press_cnt, 1);
        check("held_sel", int'({sel1, sel0}), 1);

        do_reset();
        foreach (tbl[i]) begin
            press_cnt = 0;
            sw1 = tbl[i].s1;
            sw2 = tbl[i].s2;
            repeat (tbl[i].hold) tick();
            sw1 = 0;
            sw2 = 0;
            repeat (14) tick();
            check($sformatf("tbl%0d_idx", i), int'({sel1, sel0}), tbl[i].exp_idx);
            check($sformatf("tbl%0d_presses", i), press_cnt, tbl[i].exp_press);
        end

        // Glitchy switch never qualifies.
        press_cnt = 0;
        for (int g = 0; g < 10; g++) begin
            sw1 = 1;
            repeat (5) tick();
            sw1 = 0;
            tick();
        end
        repeat (14) tick();
        check("glitch_presses", press_cnt, 0);
        check("glitch_idx", int'({sel1, sel0}), 3);

        // Reset in the middle of a qualifying press, switch held throughout.
        do_reset();
        sw1 = 1;
        repeat (4) tick();
        rst_n = 0;
        model_reset();
        #1;
        check("midpress_reset_sel", int'({sel1, sel0}), 0);
        repeat (3) tick();
        rst_n     = 1;
        press_cnt = 0;
        wait_change(40, n);
        check("requalify_latency", n, 11);
        repeat (30) tick();
        check("requalify_single_step", press_cnt, 1);
        sw1 = 0;
        repeat (14) tick();
`else
        // Auto-advance cadence, then a press restarting the idle count.
        do_reset();
        wait_change(200, n);
        check("auto_first", n, int'(AUTO));
        check("auto_no_press", press_cnt, 0);
        wait_change(200, n);
        check("auto_period", n, int'(AUTO));
        repeat (30) tick();
        sw1 = 1;
        n   = 0;
        do begin
            tick();
            n++;
        end while (!press && n < 40);
        check("auto_press_seen", int'(press), 1);
        sw1 = 0;
        wait_change(200, n);
        check("auto_after_press", n, int'(AUTO));
        check("auto_press_count", press_cnt, 1);
`endif

        // Random switch activity against the reference model.
        do_reset();
        rem1 = 1;
        rem2 = 1;
        for (int c = 0; c < 1500; c++) begin
            if (--rem1 == 0) begin
                sw1  = ~sw1;
                rem1 = $urandom_range(1, 16);
            end
            if (--rem2 == 0) begin
                sw2  = ~sw2;
                rem2 = $urandom_range(1, 16);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
